// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants for the IN/OUT port responder
package io_pkg;

    localparam int IO_DATA_W = 16;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_UDF   = 2;
    localparam int STAT_TX_OVF   = 3;

    localparam int STAT_W = 4;

endpackage

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock FIFO with first-word-fall-through head
module io_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             push_ok;
    logic             pop_ok;

    // The owner qualifies push/pop; these guards only keep the count consistent.
    assign pop_ok  = pop && (cnt != '0);
    assign push_ok = push && ((cnt != (AW+1)'(DEPTH)) || pop_ok);

    // Pointers wrap naturally; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/io_port_responder.sv
// rtl/io_port_responder.sv - device end of the IN/OUT port interface (optional IO_INT_EN interrupt)
module io_port_responder
    import io_pkg::*;
#(
    parameter int DATA_W   = IO_DATA_W,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              out_wr,
    input  logic [DATA_W-1:0] out_data,
    input  logic              in_rd,
    output logic [DATA_W-1:0] in_data,
    output logic              io_busy,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_ready,
    input  logic              status_clr,
    output logic [STAT_W-1:0] status,
    output logic              int_req
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [TAW:0]      tx_level;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [RAW:0]      rx_level;
    logic [DATA_W-1:0] rx_head;
    logic              tx_ovf_q;
    logic              rx_udf_q;
    logic              tx_ovf_set;
    logic              rx_udf_set;

    // A word may enter a full TX queue only when the head leaves in the same cycle.
    assign tx_valid   = RESET && !tx_empty;
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push    = out_wr && (!tx_full || tx_pop);
    assign tx_ovf_set = out_wr && tx_full && !tx_pop;
    assign io_busy    = RESET && (tx_level == (TAW+1)'(TX_DEPTH));

    // RX acceptance depends only on the registered fill level, never on in_rd.
    assign rx_ready   = RESET && !rx_full;
    assign rx_push    = rx_valid && rx_ready;
    assign rx_pop     = in_rd && !rx_empty;
    assign rx_udf_set = in_rd && rx_empty;
    assign in_data    = (RESET && !rx_empty) ? rx_head : '0;

    io_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .resetn (RESET),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (out_data),
        .dout   (tx_data),
        .full   (tx_full),
        .empty  (tx_empty),
        .level  (tx_level)
    );

    io_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .resetn (RESET),
        .push   (rx_push),
        .pop    (rx_pop),
        .din    (rx_data),
        .dout   (rx_head),
        .full   (rx_full),
        .empty  (rx_empty),
        .level  (rx_level)
    );

    // Sticky error flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            tx_ovf_q <= 1'b0;
            rx_udf_q <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_set || (tx_ovf_q && !status_clr);
            rx_udf_q <= rx_udf_set || (rx_udf_q && !status_clr);
        end
    end

    // Status word; held at "RX empty only" while reset is asserted.
    always_comb begin
        status = '0;
        if (!RESET) begin
            status[STAT_RX_EMPTY] = 1'b1;
        end else begin
            status[STAT_RX_EMPTY] = (rx_level == '0);
            status[STAT_TX_FULL]  = tx_full;
            status[STAT_RX_UDF]   = rx_udf_q;
            status[STAT_TX_OVF]   = tx_ovf_q;
        end
    end

`ifdef IO_INT_EN
    logic         int_req_q;
    logic [RAW:0] rx_level_next;

    assign rx_level_next = rx_level + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);

    // Interrupt flop mirrors "RX holds data" as of each edge.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            int_req_q <= 1'b0;
        end else begin
            int_req_q <= (rx_level_next != '0);
        end
    end

    assign int_req = RESET && int_req_q;
`else
    assign int_req = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// tb/tb_io_port_responder.sv - self-checking bench for io_port_responder
module tb_io_port_responder;

    localparam int DW = 16;
    localparam int TXD = 4;
    localparam int RXD = 4;
`ifdef IO_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic          clk;
    logic          RESET;
    logic          out_wr;
    logic [DW-1:0] out_data;
    logic          in_rd;
    logic [DW-1:0] in_data;
    logic          io_busy;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic          status_clr;
    logic [3:0]    status;
    logic          int_req;

    int checks = 0;
    int errors = 0;

    io_port_responder #(.DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .io_busy    (io_busy),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .status_clr (status_clr),
        .status     (status),
        .int_req    (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: two queues and two sticky bits.
    logic [DW-1:0] m_tx[$];
    logic [DW-1:0] m_rx[$];
    logic          m_ovf;
    logic          m_udf;
    logic [DW-1:0] m_log[$];
    logic [DW-1:0] d_log[$];

    initial begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
    end

    always @(posedge clk) begin
        if (!RESET) begin
            m_tx.delete();
            m_rx.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit tpop, tset, rset;
            tpop = (m_tx.size() > 0) && tx_ready;
            tset = 1'b0;
            if (tpop) m_log.push_back(m_tx.pop_front());
            if (out_wr) begin
                if (m_tx.size() < TXD) m_tx.push_back(out_data);
                else tset = 1'b1;
            end
            rset = 1'b0;
            if (in_rd && m_rx.size() == 0) rset = 1'b1;
            if (rx_valid && m_rx.size() < RXD) begin
                if (in_rd && m_rx.size() > 0) void'(m_rx.pop_front());
                m_rx.push_back(rx_data);
            end else if (in_rd && m_rx.size() > 0) begin
                void'(m_rx.pop_front());
            end
            m_ovf = tset | (m_ovf & ~status_clr);
            m_udf = rset | (m_udf & ~status_clr);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [3:0] st;
        if (!RESET) begin
            check("tx_valid_rst", tx_valid, 0);
            check("rx_ready_rst", rx_ready, 0);
            check("io_busy_rst", io_busy, 0);
            check("in_data_rst", in_data, 0);
            check("int_req_rst", int_req, 0);
            check("status_rst", status, 4'b0001);
        end else begin
            st = {m_ovf, m_udf, (m_tx.size() == TXD), (m_rx.size() == 0)};
            check("tx_valid", tx_valid, (m_tx.size() > 0));
            if (m_tx.size() > 0) check("tx_data", tx_data, m_tx[0]);
            check("io_busy", io_busy, (m_tx.size() == TXD));
            check("rx_ready", rx_ready, (m_rx.size() < RXD));
            check("in_data", in_data, (m_rx.size() > 0) ? m_rx[0] : 16'h0);
            check("status", status, st);
            check("int_req", int_req, INT_EN && (m_rx.size() > 0));
            if (tx_valid && tx_ready) d_log.push_back(tx_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_log [6];

    initial begin
        exp_log[0] = 16'hA5A5; exp_log[1] = 16'h0001; exp_log[2] = 16'h0002;
        exp_log[3] = 16'h0003; exp_log[4] = 16'h0004; exp_log[5] = 16'h0009;

        RESET = 1'b0; out_wr = 0; out_data = '0; in_rd = 0; tx_ready = 0;
        rx_valid = 0; rx_data = '0; status_clr = 0;
        repeat (3) tick();
        check("lit_reset_status", status, 4'b0001);
        check("lit_reset_txv", tx_valid, 0);
        RESET = 1'b1;
        tick();

        // Single word with the device ready.
        out_wr = 1; out_data = 16'hA5A5; tx_ready = 1;
        tick();
        out_wr = 0;
        check("lit_tx_valid", tx_valid, 1);
        check("lit_tx_data", tx_data, 16'hA5A5);
        tick();
        check("lit_tx_drained", tx_valid, 0);

        // Fill TX with the device stalled, then overflow.
        tx_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            out_wr = 1; out_data = DW'(k);
            tick();
        end
        out_data = 16'h0005;
        tick();
        out_wr = 0;
        check("lit_io_busy", io_busy, 1);
        check("lit_tx_full", status[1], 1);
        check("lit_tx_ovf", status[3], 1);
        status_clr = 1;
        tick();
        status_clr = 0;
        check("lit_ovf_clr", status[3], 0);

        // Push into a full queue while the head leaves.
        out_wr = 1; out_data = 16'h0009; tx_ready = 1;
        tick();
        out_wr = 0; tx_ready = 0;
        check("lit_full_pushpop_ovf", status[3], 0);
        check("lit_full_pushpop_busy", io_busy, 1);
        check("lit_full_pushpop_head", tx_data, 16'h0002);
        tx_ready = 1;
        repeat (5) tick();
        tx_ready = 0;
        check("lit_tx_empty_after", tx_valid, 0);

        // RX two words, drain, underflow, clear.
        rx_valid = 1; rx_data = 16'h1234;
        tick();
        check("lit_int_req", int_req, INT_EN);
        rx_data = 16'h5678;
        tick();
        rx_valid = 0;
        check("lit_rx_head1", in_data, 16'h1234);
        in_rd = 1;
        tick();
        in_rd = 0;
        check("lit_rx_head2", in_data, 16'h5678);
        in_rd = 1;
        tick();
        check("lit_rx_empty_data", in_data, 16'h0000);
        check("lit_rx_empty_flag", status[0], 1);
        check("lit_int_req_clr", int_req, 0);
        tick();
        in_rd = 0;
        check("lit_rx_udf", status[2], 1);
        status_clr = 1;
        tick();
        status_clr = 0;
        check("lit_rx_udf_clr", status[2], 0);

        // Fill RX, refused fifth word, then concurrent push and pop.
        rx_valid = 1;
        for (int k = 0; k < 4; k++) begin
            rx_data = 16'h0010 + DW'(k);
            tick();
        end
        check("lit_rx_ready_full", rx_ready, 0);
        rx_data = 16'h0014;
        tick();
        rx_valid = 0;
        check("lit_rx_no_capture", in_data, 16'h0010);
        in_rd = 1;
        tick();
        in_rd = 0;
        check("lit_rx_pop_one", in_data, 16'h0011);
        check("lit_rx_ready_back", rx_ready, 1);
        in_rd = 1; rx_valid = 1; rx_data = 16'h00FF;
        tick();
        rx_valid = 0;
        check("lit_rx_pushpop", in_data, 16'h0012);
        tick();
        check("lit_rx_13", in_data, 16'h0013);
        tick();
        check("lit_rx_ff_last", in_data, 16'h00FF);
        tick();
        in_rd = 0;
        check("lit_rx_drained", status[0], 1);

        // Reset in the middle of traffic on both paths.
        out_wr = 1; rx_valid = 1;
        out_data = 16'h0021; rx_data = 16'h0031;
        tick();
        out_data = 16'h0022; rx_data = 16'h0032;
        tick();
        out_wr = 0; rx_valid = 0;
        RESET = 1'b0;
        #1;
        check("lit_mid_rst_status", status, 4'b0001);
        check("lit_mid_rst_txv", tx_valid, 0);
        check("lit_mid_rst_int", int_req, 0);
        repeat (2) tick();
        RESET = 1'b1;
        tick();
        check("lit_post_rst_txv", tx_valid, 0);
        check("lit_post_rst_in", in_data, 16'h0000);
        check("lit_post_rst_status", status, 4'b0001);
        check("lit_post_rst_busy", io_busy, 0);
        repeat (2) tick();

        // Words seen by the device, both as modelled and as driven by the DUT.
        check("log_model_size", m_log.size(), 6);
        check("log_dut_size", d_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < m_log.size()) check("log_model", m_log[i], exp_log[i]);
            if (i < d_log.size()) check("log_dut", d_log[i], exp_log[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
